// File: rtl/otter_fetch_stage.sv
// OTTER instruction fetch: PC, one-cycle synchronous instruction read, skid FIFO to decode.
// Optional FETCH_PERF_EN adds handshake/bubble counters PERF_FETCHED and PERF_BUBBLES.
module otter_fetch_stage #(
    parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] MEM_ADDR1,
    output logic        MEM_READ1,
    input  logic [31:0] MEM_DOUT1,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_ADDR,
    output logic        IF_VALID,
    input  logic        IF_READY,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_INSTR,
    output logic        IF_MISALIGN
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] PERF_FETCHED,
    output logic [31:0] PERF_BUBBLES
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [31:0]      r_pc;
    logic             r_inflight;
    logic [31:0]      r_inflight_pc;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;

    logic [31:0]      r_mem_pc    [FIFO_DEPTH];
    logic [31:0]      r_mem_instr [FIFO_DEPTH];
    logic             r_mem_mis   [FIFO_DEPTH];

    logic             w_pop;
    logic             w_push;
    logic             w_issue;
    logic [OCC_W-1:0] w_occ;
    logic [OCC_W-1:0] w_occ_after;

    assign IF_VALID    = (r_count != '0);
    assign w_pop       = IF_VALID && IF_READY;
    assign w_occ       = OCC_W'(r_count) + OCC_W'(r_inflight);
    assign w_occ_after = w_occ - OCC_W'(w_pop);
    // Counting the in-flight read in occupancy is what keeps a push from ever hitting a full FIFO.
    assign w_issue     = !RST && !REDIRECT && (w_occ_after < OCC_W'(FIFO_DEPTH));
    assign w_push      = r_inflight && !REDIRECT;

    assign MEM_READ1   = w_issue;
    assign MEM_ADDR1   = w_issue ? {r_pc[31:2], 2'b00} : r_pc;

    assign IF_PC       = IF_VALID ? r_mem_pc[r_rd_ptr]    : 32'h0;
    assign IF_INSTR    = IF_VALID ? r_mem_instr[r_rd_ptr] : 32'h0;
    assign IF_MISALIGN = IF_VALID ? r_mem_mis[r_rd_ptr]   : 1'b0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc          <= RESET_VEC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_VEC;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else if (REDIRECT) begin
            r_pc       <= REDIRECT_ADDR;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            if (w_issue) begin
                r_pc          <= r_pc + 32'd4;
                r_inflight_pc <= r_pc;
            end
            r_inflight <= w_issue;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Payload storage needs no reset; visibility is governed by r_count alone.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
            r_mem_instr[r_wr_ptr] <= MEM_DOUT1;
            r_mem_mis[r_wr_ptr]   <= (r_inflight_pc[1:0] != 2'b00);
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubbles;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_perf_fetched <= 32'h0;
            r_perf_bubbles <= 32'h0;
        end else begin
            if (w_pop) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (IF_READY && !IF_VALID) begin
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
            end
        end
    end

    assign PERF_FETCHED = r_perf_fetched;
    assign PERF_BUBBLES = r_perf_bubbles;
`endif

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Bench for otter_fetch_stage: directed test-plan steps, then randomized ready/redirect
// traffic checked against an in-order stream model of expected PCs and outstanding fetches.
module tb_otter_fetch_stage;
    localparam logic [31:0] RESET_VEC  = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] MEM_ADDR1;
    logic        MEM_READ1;
    logic [31:0] MEM_DOUT1 = 32'h0;
    logic        REDIRECT;
    logic [31:0] REDIRECT_ADDR;
    logic        IF_VALID;
    logic        IF_READY;
    logic [31:0] IF_PC;
    logic [31:0] IF_INSTR;
    logic        IF_MISALIGN;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    int vectors;
    int miscompares;

    // Reference model: next PC decode should see, next PC fetch should request.
    logic [31:0] exp_pc;
    logic [31:0] fetch_pc;
    int          since_redir;
    logic        stall_pending;
    int          hs_count;
    int          bubble_count;

    otter_fetch_stage #(
        .RESET_VEC (RESET_VEC),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .MEM_ADDR1    (MEM_ADDR1),
        .MEM_READ1    (MEM_READ1),
        .MEM_DOUT1    (MEM_DOUT1),
        .REDIRECT     (REDIRECT),
        .REDIRECT_ADDR(REDIRECT_ADDR),
        .IF_VALID     (IF_VALID),
        .IF_READY     (IF_READY),
        .IF_PC        (IF_PC),
        .IF_INSTR     (IF_INSTR),
        .IF_MISALIGN  (IF_MISALIGN)
`ifdef FETCH_PERF_EN
        ,
        .PERF_FETCHED (perf_fetched),
        .PERF_BUBBLES (perf_bubbles)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    // Instruction memory: word k holds 0x1000_0000 + k, updated only on strobed reads.
    always @(posedge CLK) begin
        if (MEM_READ1) begin
            MEM_DOUT1 <= word_at(MEM_ADDR1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs after the falling edge, then check against the model.
    task automatic step(input logic rst, input logic rdy, input logic redir, input logic [31:0] raddr);
        logic [31:0] occ;
        logic        pop;
        logic        exp_read;
        @(negedge CLK);
        RST           = rst;
        IF_READY      = rdy;
        REDIRECT      = redir;
        REDIRECT_ADDR = raddr;
        #1;
        if (rst) begin
            chk("rst_if_valid", {31'b0, IF_VALID}, 32'd0);
            chk("rst_mem_read", {31'b0, MEM_READ1}, 32'd0);
            chk("rst_mem_addr", MEM_ADDR1, RESET_VEC);
            chk("rst_if_pc", IF_PC, 32'h0);
            chk("rst_if_instr", IF_INSTR, 32'h0);
            chk("rst_if_misalign", {31'b0, IF_MISALIGN}, 32'd0);
            exp_pc        = RESET_VEC;
            fetch_pc      = RESET_VEC;
            since_redir   = 99;
            stall_pending = 1'b0;
            hs_count      = 0;
            bubble_count  = 0;
        end else begin
            pop      = IF_VALID && IF_READY;
            occ      = (fetch_pc - exp_pc) >> 2;
            exp_read = !redir && ((occ - {31'b0, pop}) < FIFO_DEPTH);
            chk("mem_read", {31'b0, MEM_READ1}, {31'b0, exp_read});
            if (exp_read) begin
                chk("mem_addr", MEM_ADDR1, {fetch_pc[31:2], 2'b00});
                fetch_pc = fetch_pc + 32'd4;
            end
            if (since_redir == 1 || since_redir == 2) begin
                chk("redir_bubble", {31'b0, IF_VALID}, 32'd0);
            end
            if (stall_pending) begin
                chk("stall_hold_valid", {31'b0, IF_VALID}, 32'd1);
            end
            if (IF_VALID) begin
                chk("head_pc", IF_PC, exp_pc);
                chk("head_instr", IF_INSTR, word_at(exp_pc));
                chk("head_misalign", {31'b0, IF_MISALIGN}, {31'b0, (exp_pc[1:0] != 2'b00)});
            end
            if (IF_READY && !IF_VALID) begin
                bubble_count++;
            end
            if (pop) begin
                $display("handshake pc=%h instr=%h misalign=%0d", IF_PC, IF_INSTR, IF_MISALIGN);
                exp_pc = exp_pc + 32'd4;
                hs_count++;
            end
            stall_pending = IF_VALID && !IF_READY && !redir;
            if (redir) begin
                exp_pc      = raddr;
                fetch_pc    = raddr;
                since_redir = 0;
            end
            if (since_redir < 99) begin
                since_redir++;
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic        r;
        logic        d;
        vectors       = 0;
        miscompares   = 0;
        RST           = 1'b1;
        IF_READY      = 1'b0;
        REDIRECT      = 1'b0;
        REDIRECT_ADDR = 32'h0;
        exp_pc        = RESET_VEC;
        fetch_pc      = RESET_VEC;
        since_redir   = 99;
        stall_pending = 1'b0;
        hs_count      = 0;
        bubble_count  = 0;

        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Reset release: issue at once, first valid two cycles later.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("first_issue", {31'b0, MEM_READ1}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("cyc1_valid", {31'b0, IF_VALID}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("cyc2_valid", {31'b0, IF_VALID}, 32'd1);
        chk("cyc2_pc", IF_PC, 32'h0);
        chk("cyc2_instr", IF_INSTR, 32'h1000_0000);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("cyc3_pc", IF_PC, 32'h4);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("cyc4_pc", IF_PC, 32'h8);

        // Backpressure for five cycles, then release.
        repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("stall_read_stopped", {31'b0, MEM_READ1}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("release_pc", IF_PC, 32'hC);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("release_stream_pc", IF_PC, 32'h18);

        // Redirect with a full pipeline.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("redir_valid", {31'b0, IF_VALID}, 32'd1);
        chk("redir_pc", IF_PC, 32'h100);
        chk("redir_instr", IF_INSTR, 32'h1000_0040);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("redir_next_pc", IF_PC, 32'h104);

        // Misaligned redirect target.
        step(1'b0, 1'b1, 1'b1, 32'h0000_0102);
        repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("mis_pc", IF_PC, 32'h102);
        chk("mis_instr", IF_INSTR, 32'h1000_0040);
        chk("mis_flag", {31'b0, IF_MISALIGN}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("mis_next_pc", IF_PC, 32'h106);
        chk("mis_next_instr", IF_INSTR, 32'h1000_0041);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("wrap_pc", IF_PC, 32'h0);
        chk("wrap_instr", IF_INSTR, 32'h1000_0000);

        // Randomized ready and redirect traffic.
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 99) < 70);
            d = ($urandom_range(0, 99) < 6);
            a = $urandom;
            case ($urandom_range(0, 3))
                0: a[1:0] = 2'b00;
                1: a = 32'hFFFF_FFF0 | (a & 32'h0000_000F);
                default: a = a & 32'h0000_0FFF;
            endcase
            step(1'b0, r, d, a);
        end

        // Drain with ready held: the stream must keep flowing.
        repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("drain_valid", {31'b0, IF_VALID}, 32'd1);

        // Asynchronous reset mid-stream, then restart from the reset vector.
        chk("pre_reset_valid", {31'b0, IF_VALID}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("restart_issue_addr", MEM_ADDR1, RESET_VEC);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("restart_pc", IF_PC, RESET_VEC);
        repeat (9) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("restart_handshakes", hs_count, 32'd10);

`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 32'd10);
        chk("perf_bubbles", perf_bubbles, 32'd2);
        chk("perf_bubbles_model", perf_bubbles, bubble_count);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
